// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath.
// Ports: clk, rst_n (async low), run, opcode, zero, mem_ready in;
// datapath enables/selects, state, halted, illegal out.
// Optional: MC_CTRL_MEM_WAIT_EN makes memory states wait for mem_ready.
module multicycle_control_fsm #(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal
);

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit MemWait = 1'b1;
`else
  localparam bit MemWait = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  state_t state_q;
  state_t ns;
  ctrl_t  ctrl_q;

  logic halt_op, r_op, i_op, m_op, b_op, j_op;
  logic hold, done_ns_go;

  assign halt_op = opcode == HALT_OPCODE;
  assign r_op = !halt_op && opcode <= 4'h5;
  assign i_op = !halt_op &&
                (opcode == 4'h6 || opcode == 4'hC);
  assign m_op = !halt_op &&
                (opcode == 4'h7 || opcode == 4'h8);
  assign b_op = !halt_op &&
                (opcode == 4'h9 || opcode == 4'hA);
  assign j_op = !halt_op && opcode == 4'hB;

  assign hold = MemWait && !mem_ready;
  assign done_ns_go = run;

  always_comb begin
    ns = S_IDLE;
    case (state_q)
      S_IDLE:   ns = run ? S_FETCH : S_IDLE;
      S_FETCH:  ns = hold ? S_FETCH : S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          halt_op: ns = S_HALT;
          r_op:    ns = S_EXEC_R;
          i_op:    ns = S_EXEC_I;
          m_op:    ns = S_MEM_ADDR;
          b_op:    ns = S_BRANCH;
          j_op:    ns = S_JUMP;
          default: ns = done_ns_go ? S_FETCH : S_IDLE;
        endcase
      end
      S_EXEC_R, S_EXEC_I: ns = S_WB_ALU;
      S_MEM_ADDR:
        ns = (opcode == 4'h7) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: ns = hold ? S_MEM_RD : S_WB_MEM;
      S_MEM_WR:
        ns = hold ? S_MEM_WR :
             (done_ns_go ? S_FETCH : S_IDLE);
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP:
        ns = done_ns_go ? S_FETCH : S_IDLE;
      S_HALT:  ns = S_HALT;
      default: ns = S_IDLE;
    endcase
  end

  // Outputs are precomputed for the state being entered so that
  // they come straight out of flops.
  function automatic ctrl_t ctrl_of(input state_t s,
                                    input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      S_DECODE: c.alu_src_b = 2'd2;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = op[2:0];
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = (op == 4'hC) ? 3'd6 : 3'd0;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_WB_ALU: c.reg_write = 1'b1;
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'd1;
        c.pc_src    = 2'd1;
      end
      S_JUMP: begin
        c.pc_src   = 2'd2;
        c.pc_write = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= ns;
      ctrl_q  <= ctrl_of(ns, opcode);
    end
  end

  logic fetch_go, br_take;

  // IR/PC load only on the fetch cycle where memory responds.
  assign fetch_go = !(MemWait && state_q == S_FETCH &&
                      !mem_ready);
  assign br_take = state_q == S_BRANCH &&
                   (opcode == 4'hA ? !zero : zero);

  assign pc_write   = (ctrl_q.pc_write && fetch_go) || br_take;
  assign ir_write   = ctrl_q.ir_write && fetch_go;
  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign halted     = ctrl_q.halted;
  assign state      = state_q;
  assign illegal    = state_q == S_DECODE && !halt_op &&
                      (opcode == 4'hD || opcode == 4'hE);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm.
// Covers MC_CTRL_MEM_WAIT_EN waits when that macro is defined.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       pc_write, ir_write, iord;
  logic       mem_read, mem_write;
  logic       reg_write, mem_to_reg, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       halted, illegal;
  logic [16:0] allo;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state),
    .halted(halted), .illegal(illegal)
  );

  assign allo = {pc_write, pc_src, ir_write, iord,
                 mem_read, mem_write, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b,
                 alu_op, halted, illegal};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nx(input logic [3:0] s);
    @(negedge clk);
    chk("state", state, s);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_state", state, 4'd0);
    chk("rst_outs", allo, 17'd0);

    // ADD
    rst_n = 1'b1;
    run = 1'b1;
    opcode = 4'h0;
    nx(1);
    chk("f_strobes", {mem_read, ir_write, pc_write, iord},
        4'b1110);
    chk("f_alu", {alu_src_a, alu_src_b, alu_op}, 6'b001000);
    nx(2);
    chk("d_srcb", alu_src_b, 2'd2);
    nx(3);
    chk("er_alu", {alu_src_a, alu_src_b, alu_op}, 6'b100000);
    chk("er_rw", reg_write, 1'b0);
    nx(8);
    chk("wb_rw", {reg_write, mem_to_reg}, 2'b10);
    nx(1);

    // LW
    opcode = 4'h7;
    nx(2);
    nx(5);
    chk("ma_alu", {alu_src_a, alu_src_b, alu_op}, 6'b110000);
    nx(6);
    chk("mr", {mem_read, iord, mem_write}, 3'b110);
    nx(9);
    chk("wm", {reg_write, mem_to_reg}, 2'b11);
    nx(1);

    // BEQ taken, then zero dropped mid-cycle
    opcode = 4'h9;
    zero = 1'b1;
    nx(2);
    nx(10);
    chk("beq_pcw", pc_write, 1'b1);
    chk("beq_sel", {pc_src, alu_src_a, alu_src_b, alu_op},
        8'b01100001);
    zero = 1'b0;
    #1 chk("beq_nz", pc_write, 1'b0);
    nx(1);

    // BNE
    opcode = 4'hA;
    zero = 1'b1;
    nx(2);
    nx(10);
    chk("bne_z", pc_write, 1'b0);
    zero = 1'b0;
    #1 chk("bne_nz", pc_write, 1'b1);
    nx(1);

    // JMP
    opcode = 4'hB;
    nx(2);
    nx(11);
    chk("jmp", {pc_write, pc_src}, 3'b110);
    nx(1);

    // Illegal
    opcode = 4'hD;
    chk("ill_pre", illegal, 1'b0);
    nx(2);
    chk("ill", illegal, 1'b1);
    nx(1);
    chk("ill_post", illegal, 1'b0);

    // ADDI
    opcode = 4'h6;
    nx(2);
    nx(4);
    chk("addi", {alu_src_a, alu_src_b, alu_op}, 6'b110000);
    nx(8);
    nx(1);

    // LUI
    opcode = 4'hC;
    nx(2);
    nx(4);
    chk("lui", {alu_src_a, alu_src_b, alu_op}, 6'b110110);
    nx(8);
    nx(1);
    opcode = 4'h8;

`ifdef MC_CTRL_MEM_WAIT_EN
    // Fetch wait: three stalled cycles, load on the fourth
    mem_ready = 1'b0;
    #1 chk("fw_ir", {mem_read, ir_write, pc_write}, 3'b100);
    nx(1);
    #1 chk("fw_ir", {mem_read, ir_write, pc_write}, 3'b100);
    nx(1);
    #1 chk("fw_ir", {mem_read, ir_write, pc_write}, 3'b100);
    nx(1);
    mem_ready = 1'b1;
    #1 chk("fw_go", {mem_read, ir_write, pc_write}, 3'b111);
    nx(2);
    nx(5);
    mem_ready = 1'b0;
    nx(7);
    chk("sww", {mem_write, iord}, 2'b11);
    nx(7);
    nx(7);
    chk("sww", {mem_write, iord}, 2'b11);
    nx(7);
    mem_ready = 1'b1;
    nx(1);
`endif

    // SW with run dropped: store still completes
    nx(2);
    run = 1'b0;
    nx(5);
    nx(7);
    chk("sw", {mem_write, iord, mem_read}, 3'b110);
    nx(0);
    chk("idle_outs", allo, 17'd0);
    nx(0);
    run = 1'b1;
    nx(1);
    opcode = 4'h8;
    nx(2);
    nx(5);
    nx(7);
    chk("sw2", mem_write, 1'b1);

    // Async reset mid-store
    #2 rst_n = 1'b0;
    #1 chk("rst_mw", mem_write, 1'b0);
    chk("rst_st", state, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    opcode = 4'hF;
    nx(1);
    nx(2);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      nx(12);
      chk("halt_outs", allo, 17'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
